// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative RV32M multiply/divide unit beside the Execute-stage ALU.
// It computes one bit per cycle on operand magnitudes and fixes up the sign at the end.
// It holds F/D/E through StallMD_o until the result is ready.
// Optional build macro EXECUTE_MULDIV_FAST_MUL_EN computes multiplies combinationally,
// going IDLE->DONE. Divides always iterate.
module execute_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  StartE_i,
    input  logic [2:0]            MulDivOpE_i,
    input  logic [DATA_WIDTH-1:0] RD1E_i,
    input  logic [DATA_WIDTH-1:0] RD2E_i,
    input  logic [DATA_WIDTH-1:0] ResultW_i,
    input  logic [DATA_WIDTH-1:0] ALUResultM_i,
    input  logic [1:0]            ForwardAEctrl_i,
    input  logic [1:0]            ForwardBEctrl_i,
    input  logic                  FlushE_i,
    input  logic [4:0]            RdE_i,
    output logic                  StallMD_o,
    output logic                  DoneE_o,
    output logic [DATA_WIDTH-1:0] ResultE_o,
    output logic [4:0]            RdE_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;

    logic [W-1:0]  src_a, src_b, mag_a, mag_b, special_res;
    logic          start, is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf, short_path;
    logic [2:0]    op;
    logic [4:0]    rd;
    logic [CW-1:0] count;
    logic [W-1:0]  hi, lo, mcand, res, last_res;
    logic          neg_res, neg_rem;
    logic [W:0]    sum, shifted, diff;
    logic [W-1:0]  step_hi, step_lo;

    // Apply the sign fix-up and select the architectural result from the raw hi/lo pair.
    function automatic logic [W-1:0] fix_result(input logic [2:0] f_op, input logic f_neg_res,
                                                input logic f_neg_rem, input logic [W-1:0] f_hi,
                                                input logic [W-1:0] f_lo);
        logic [2*W-1:0] prod;
        logic [W-1:0]   r;
        prod = f_neg_res ? -{f_hi, f_lo} : {f_hi, f_lo};
        if (!f_op[2])
            r = (f_op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        else if (!f_op[1])
            r = f_neg_res ? -f_lo : f_lo;
        else
            r = f_neg_rem ? -f_hi : f_hi;
        return r;
    endfunction

    // Forwarding muxes and start-time decode of signedness and special divide cases.
    always_comb begin
        case (ForwardAEctrl_i)
            2'b01:   src_a = ResultW_i;
            2'b10:   src_a = ALUResultM_i;
            default: src_a = RD1E_i;
        endcase
        case (ForwardBEctrl_i)
            2'b01:   src_b = ResultW_i;
            2'b10:   src_b = ALUResultM_i;
            default: src_b = RD2E_i;
        endcase
        start    = StartE_i && !FlushE_i;
        is_div   = MulDivOpE_i[2];
        // MUL is treated as unsigned: the low half of the product is identical either way.
        sgn_a    = (MulDivOpE_i == 3'b001) || (MulDivOpE_i == 3'b010) ||
                   (MulDivOpE_i == 3'b100) || (MulDivOpE_i == 3'b110);
        sgn_b    = (MulDivOpE_i == 3'b001) || (MulDivOpE_i == 3'b100) || (MulDivOpE_i == 3'b110);
        a_neg    = sgn_a && src_a[W-1];
        b_neg    = sgn_b && src_b[W-1];
        mag_a    = a_neg ? -src_a : src_a;
        mag_b    = b_neg ? -src_b : src_b;
        div_zero = is_div && (src_b == '0);
        div_ovf  = is_div && !MulDivOpE_i[0] && (src_a == {1'b1, {(W-1){1'b0}}}) && (src_b == '1);
        if (div_zero)
            special_res = MulDivOpE_i[1] ? src_a : '1;
        else
            special_res = MulDivOpE_i[1] ? '0 : src_a;
`ifdef EXECUTE_MULDIV_FAST_MUL_EN
        short_path = div_zero || div_ovf || !is_div;
`else
        short_path = div_zero || div_ovf;
`endif
    end

`ifdef EXECUTE_MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_prod;
    logic [W-1:0]   fast_res;
    // Full-width product of the sign-extended operands for the single-cycle multiply path.
    always_comb begin
        fast_prod = {{W{a_neg}}, src_a} * {{W{b_neg}}, src_b};
        fast_res  = (MulDivOpE_i[1:0] == 2'b00) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
    end
`endif

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        shifted = {hi, lo[W-1]};
        diff    = shifted - {1'b0, mcand};
        if (!op[2]) begin
            step_hi = sum[W:1];
            step_lo = {sum[0], lo[W-1:1]};
        end else if (!diff[W]) begin
            step_hi = diff[W-1:0];
            step_lo = {lo[W-2:0], 1'b1};
        end else begin
            step_hi = shifted[W-1:0];
            step_lo = {lo[W-2:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic, stall and done; flush overrides everything.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = short_path ? DONE : CALC;
            CALC:    if (count == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (FlushE_i) state_nxt = IDLE;
        StallMD_o = ((state == IDLE) && start) || (state == CALC);
        DoneE_o   = (state == DONE) && !FlushE_i;
        ResultE_o = DoneE_o ? res : last_res;
    end

    // Operand capture at start and iterative datapath update in CALC.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op <= '0; rd <= '0; count <= '0; hi <= '0; lo <= '0; mcand <= '0;
            res <= '0; neg_res <= 1'b0; neg_rem <= 1'b0;
        end else if (state == IDLE && start) begin
            op      <= MulDivOpE_i;
            rd      <= RdE_i;
            count   <= CW'(W - 1);
            hi      <= '0;
            lo      <= is_div ? mag_a : mag_b;
            mcand   <= is_div ? mag_b : mag_a;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
`ifdef EXECUTE_MULDIV_FAST_MUL_EN
            if (!is_div)
                res <= fast_res;
            else if (div_zero || div_ovf)
                res <= special_res;
`else
            if (div_zero || div_ovf) res <= special_res;
`endif
        end else if (state == CALC) begin
            hi    <= step_hi;
            lo    <= step_lo;
            count <= count - 1'b1;
            if (count == '0) res <= fix_result(op, neg_res, neg_rem, step_hi, step_lo);
        end
    end

    // Result hold register: only a delivered (unflushed) done updates the visible result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                          last_res <= '0;
        else if (state == DONE && !FlushE_i)   last_res <= res;
    end

    assign RdE_o = rd;

endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Multi-cycle RV32M multiply/divide unit that sits beside the single-cycle ALU in the Execute stage. It has the same register-forwarding mux and encodings as the Execute stage, and captures operands when an M-extension instruction issues. It iterates one bit per cycle and holds the pipeline through a stall line to the hazard unit until the result is ready. Width is parametrised.

## Interface
- DATA_WIDTH, 32, operand/result width; must be even and ≥ 8
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- StartE_i  in  1  M-extension instruction valid in Execute this cycle
- MulDivOpE_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- RD1E_i, RD2E_i  in  DATA_WIDTH  register file operands
- ResultW_i, ALUResultM_i  in  DATA_WIDTH  forwarding sources
- ForwardAEctrl_i, ForwardBEctrl_i  in  2  00 RDxE, 01 ResultW, 10 ALUResultM, 11 RDxE
- FlushE_i  in  1  kill the in-flight operation
- RdE_i  in  5  destination register of the issuing instruction
- StallMD_o  out  1  hazard unit must freeze F/D/E
- DoneE_o  out  1  one-cycle pulse; ResultE_o valid
- ResultE_o  out  DATA_WIDTH  result; held until next done
- RdE_o  out  5  destination captured at start

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - A start is StartE_i=1 with FlushE_i=0. On a start, latch the forwarded operands A/B, the opcode and RdE_i.
  - Divide-by-zero or signed overflow (DIV/REM with A=most-negative, B=−1) → go to DONE.
  - Otherwise go to CALC and load count = DATA_WIDTH−1.
- CALC:
  - Each cycle: one shift-add (multiply) or one restoring shift-subtract (divide) step, then count decrements.
  - When count = 0 and the step completes, go to DONE.
- DONE:
  - Assert DoneE_o, drive ResultE_o from the result register, then return to IDLE.
  - StartE_i is ignored in DONE.
- Signed handling:
  - Operate on magnitudes, then fix up the sign.
  - MULH: both operands signed. MULHSU: A signed, B unsigned. MULHU: both unsigned.
  - MUL returns the low DATA_WIDTH bits of the 2·DATA_WIDTH product; the MULH* ops return the high bits.
  - DIV quotient rounds toward zero. REM takes the sign of the dividend.
- Special results:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → A.
  - Signed overflow: DIV → A; REM → 0.
- StallMD_o = (state==IDLE && start) || state==CALC.
  - It is combinational, so the issuing instruction stalls in its own cycle.
  - It deasserts in DONE, so the instruction advances on the cycle its result is valid.
- FlushE_i: from any state, the next state is IDLE. A pending DoneE_o is suppressed and ResultE_o keeps its previous value. Flush has priority over start.

## Timing
- Reset (async assert, synchronous release): state IDLE, StallMD_o 0, DoneE_o 0, ResultE_o 0, RdE_o 0, and all internal registers 0.
- Latency, with the start sampled at edge 0:
  - Iterative ops: CALC occupies cycles 1..DATA_WIDTH; DoneE_o is high in cycle DATA_WIDTH+1 (33 for the default).
  - Special-case divides: DoneE_o is high in cycle 1.
- Throughput: the next start is accepted at the earliest in the cycle after DONE.
- Operands are sampled only at start. Forwarding sources may change freely afterwards.
- A reset asserted mid-operation returns the block to IDLE immediately, with all outputs at their reset values.

## Configuration
- EXECUTE_MULDIV_FAST_MUL_EN:
  - Defined: the multiply ops compute the full product combinationally from the latched operands and go IDLE→DONE, so DoneE_o is high in cycle 1. Divides are unchanged.
  - Undefined: all multiplies use the iterative CALC path (DATA_WIDTH+1 latency).
  - Results are identical in both builds.

## Test plan
- MUL, A=7, B=0xFFFFFFFD → ResultE_o=0xFFFFFFEB.
  - Without macro: DoneE_o in cycle 33, StallMD_o high cycles 0–32.
  - With macro: DoneE_o in cycle 1.
- MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5, with DoneE_o in cycle 1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Forwarding: ForwardAEctrl_i=10 with ALUResultM_i=6; ForwardBEctrl_i=01 with ResultW_i=3; RD1E_i/RD2E_i hold garbage.
  - MUL → 18, computed from the forwarded values.
  - Forward inputs change after start → result is unaffected.
- Flush and reset mid-operation:
  - FlushE_i in cycle 10 of a DIV → IDLE next cycle, no DoneE_o, ResultE_o unchanged; a new MUL 3×4 started next gives 12.
  - rst_n_i low mid-CALC → all outputs 0 immediately.
